// File: rtl/mult_pipe_elastic.sv
// mult_pipe_elastic: signed fixed-point multiplier behind an elastic valid/ready
// pipeline. Each stage holds a valid bit, and bubbles collapse.
// The product is rounded and range-checked before stage 0. The later stages only
// carry the result, its caller tag and its status.
// Optional feature: define MULT_PIPE_SKID_EN to add a 2-entry output skid buffer.
// With the buffer, in_ready depends only on registers.
// STAGES defaults to PIPELINE_ORDER, which falls back to 4 if it is not defined.

`ifndef PIPELINE_ORDER
`define PIPELINE_ORDER 4
`endif

module mult_pipe_elastic #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int STAGES     = `PIPELINE_ORDER,
  parameter int ID_WIDTH   = $clog2(`PIPELINE_ORDER) + 1,
  parameter int SAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_a,
  input  logic [DATA_WIDTH-1:0]        in_b,
  input  logic [ID_WIDTH-1:0]          in_id,
  input  logic [1:0]                   rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_z,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [2:0]                   status,
  output logic [$clog2(STAGES+3)-1:0]  census
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(STAGES + 3);
  localparam logic signed [PW-1:0] MAX_V = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [PW-1:0] a_ext, b_ext, p, r_floor, r_rnd;
  logic                 half, sticky, inc, ovf;
  logic [W-1:0]         z_new;
  logic [2:0]           st_new;

  assign a_ext   = {{W{in_a[W-1]}}, in_a};
  assign b_ext   = {{W{in_b[W-1]}}, in_b};
  assign p       = a_ext * b_ext;
  assign r_floor = p >>> FRAC_BITS;

  // half: the first discarded bit of p. sticky: OR of the discarded bits below it.
  if (FRAC_BITS == 0) begin : g_no_frac
    assign half   = 1'b0;
    assign sticky = 1'b0;
  end else if (FRAC_BITS == 1) begin : g_one_frac
    assign half   = p[0];
    assign sticky = 1'b0;
  end else begin : g_frac
    assign half   = p[FRAC_BITS-1];
    assign sticky = |p[FRAC_BITS-2:0];
  end

  // Round increment, then range check and clamp or wrap, then build status.
  always_comb begin
    inc = 1'b0;
    case (rnd)
      2'd1:    inc = half;
      2'd2:    inc = half & (sticky | r_floor[0]);
      default: inc = 1'b0;
    endcase
    r_rnd = r_floor + PW'(inc);
    ovf   = (r_rnd > MAX_V) || (r_rnd < MIN_V);
    if (ovf && (SAT != 0))
      z_new = r_rnd[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      z_new = r_rnd[W-1:0];
    st_new = {(z_new == '0), (half | sticky), ovf};
  end

  logic [STAGES-1:0] v_q, en;
  logic [W-1:0]        z_q  [STAGES];
  logic [ID_WIDTH-1:0] id_q [STAGES];
  logic [2:0]          st_q [STAGES];
  logic                last_go, avail, in_xfer, out_xfer;

  // A stage can load if it, or any stage downstream of it, is empty, or if the tail drains.
  always_comb begin
    en    = '0;
    avail = last_go;
    for (int k = STAGES - 1; k >= 0; k--) begin
      avail = avail | ~v_q[k];
      en[k] = avail;
    end
  end

  assign in_ready = en[0];
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Stage registers: each stage takes the previous stage's entry whenever it is allowed to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        z_q[k]  <= '0;
        id_q[k] <= '0;
        st_q[k] <= '0;
      end
    end else begin
      if (en[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          z_q[0]  <= z_new;
          id_q[0] <= in_id;
          st_q[0] <= st_new;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            z_q[k]  <= z_q[k-1];
            id_q[k] <= id_q[k-1];
            st_q[k] <= st_q[k-1];
          end
        end
      end
    end
  end

`ifdef MULT_PIPE_SKID_EN
  logic [1:0]          sk_cnt;
  logic [W-1:0]        sk_z  [2];
  logic [ID_WIDTH-1:0] sk_id [2];
  logic [2:0]          sk_st [2];
  logic                sk_push, sk_pop;

  assign last_go   = (sk_cnt != 2'd2);
  assign sk_push   = v_q[STAGES-1] & last_go;
  assign sk_pop    = (sk_cnt != 2'd0) & out_ready;
  assign out_valid = (sk_cnt != 2'd0);
  assign out_z     = sk_z[0];
  assign out_id    = sk_id[0];
  assign status    = sk_st[0];

  // Two-entry skid buffer. Entry 0 is the head that drives the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_cnt <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        sk_z[k]  <= '0;
        sk_id[k] <= '0;
        sk_st[k] <= '0;
      end
    end else begin
      if (sk_pop) begin
        if (sk_cnt == 2'd2) begin
          sk_z[0]  <= sk_z[1];
          sk_id[0] <= sk_id[1];
          sk_st[0] <= sk_st[1];
        end else if (sk_push) begin
          sk_z[0]  <= z_q[STAGES-1];
          sk_id[0] <= id_q[STAGES-1];
          sk_st[0] <= st_q[STAGES-1];
        end
      end else if (sk_push) begin
        if (sk_cnt == 2'd0) begin
          sk_z[0]  <= z_q[STAGES-1];
          sk_id[0] <= id_q[STAGES-1];
          sk_st[0] <= st_q[STAGES-1];
        end else begin
          sk_z[1]  <= z_q[STAGES-1];
          sk_id[1] <= id_q[STAGES-1];
          sk_st[1] <= st_q[STAGES-1];
        end
      end
      case ({sk_push, sk_pop})
        2'b10:   sk_cnt <= sk_cnt + 2'd1;
        2'b01:   sk_cnt <= sk_cnt - 2'd1;
        default: sk_cnt <= sk_cnt;
      endcase
    end
  end
`else
  assign last_go   = out_ready;
  assign out_valid = v_q[STAGES-1];
  assign out_z     = z_q[STAGES-1];
  assign out_id    = id_q[STAGES-1];
  assign status    = st_q[STAGES-1];
`endif

  // Occupancy counter: follows the in/out transfers, so it always equals the number of set valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      census <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   census <= census + CW'(1);
        2'b01:   census <= census - CW'(1);
        default: census <= census;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_pipe_elastic.sv
// Testbench for mult_pipe_elastic. A driver pushes the expected results into a queue.
// A monitor pops that queue and compares on every output transfer.
module tb_mult_pipe_elastic;

  localparam int W  = 16;
  localparam int IW = 4;
  localparam int S  = 4;
  localparam int CW = $clog2(S + 3);
`ifdef MULT_PIPE_SKID_EN
  localparam int LAT  = S + 1;
  localparam int CMAX = S + 2;
`else
  localparam int LAT  = S;
  localparam int CMAX = S;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_a = '0, in_b = '0, out_z;
  logic [IW-1:0] in_id = '0, out_id;
  logic [1:0]    rnd = '0;
  logic [2:0]    status;
  logic [CW-1:0] census;

  mult_pipe_elastic #(.DATA_WIDTH(W), .FRAC_BITS(8), .STAGES(S), .ID_WIDTH(IW), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_id(in_id), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_id(out_id),
    .status(status), .census(census));

  logic          w_in_valid = 1'b0;
  logic          w_in_ready, w_out_valid;
  logic [W-1:0]  w_in_a = '0, w_in_b = '0, w_out_z;
  logic [IW-1:0] w_out_id;
  logic [2:0]    w_status;
  logic [CW-1:0] w_census;

  mult_pipe_elastic #(.DATA_WIDTH(W), .FRAC_BITS(8), .STAGES(S), .ID_WIDTH(IW), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_id(4'd1), .rnd(2'd0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_z(w_out_z), .out_id(w_out_id),
    .status(w_status), .census(w_census));

  typedef struct {
    logic [W-1:0]  z;
    logic [IW-1:0] id;
    logic [2:0]    st;
    int            acc;
    bit            chk_lat;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got id %0h z %0h expected no output", out_id, out_z);
      end else begin
        e_mon = q.pop_front();
        check("out_z", 32'(out_z), 32'(e_mon.z));
        check("out_id", 32'(out_id), 32'(e_mon.id));
        check("status", 32'(status), 32'(e_mon.st));
        if (e_mon.chk_lat) check("latency", 32'(cyc - e_mon.acc), 32'(LAT));
      end
    end
  end

  // Occupancy model built from the observed handshakes.
  int cmodel = 0;
  int cpeak  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cmodel = 0;
    end else begin
      check("census", 32'(census), 32'(cmodel));
      if (int'(census) > cpeak) cpeak = int'(census);
      cmodel = cmodel + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  // Call at posedge+#1. Holds the operands until they are accepted, then returns at posedge+#1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] r,
                      input logic [IW-1:0] id, input logic [W-1:0] z, input logic [2:0] st,
                      input bit cl);
    exp_t ex;
    bit   done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    rnd      = r;
    in_id    = id;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ex.z = z; ex.id = id; ex.st = st; ex.acc = cyc; ex.chk_lat = cl;
        q.push_back(ex);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: id %0h not accepted, got in_ready=0 expected 1", id);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    r;
    logic [IW-1:0] id;
    logic [W-1:0]  z;
    logic [2:0]    st;
  } vec_t;

  localparam int NV = 11;
  localparam vec_t VECS [NV] = '{
    '{16'h0180, 16'h0200, 2'd0, 4'd3,  16'h0300, 3'b000},
    '{16'h0001, 16'h0080, 2'd0, 4'd1,  16'h0000, 3'b110},
    '{16'h0001, 16'h0080, 2'd1, 4'd2,  16'h0001, 3'b010},
    '{16'h0001, 16'h0080, 2'd2, 4'd4,  16'h0000, 3'b110},
    '{16'h7FFF, 16'h7FFF, 2'd0, 4'd5,  16'h7FFF, 3'b011},
    '{16'h8000, 16'h7FFF, 2'd0, 4'd6,  16'h8000, 3'b001},
    '{16'hFF00, 16'h0100, 2'd0, 4'd7,  16'hFF00, 3'b000},
    '{16'hFFFF, 16'h0080, 2'd1, 4'd8,  16'h0000, 3'b110},
    '{16'hFFFF, 16'h0080, 2'd3, 4'd9,  16'hFFFF, 3'b010},
    '{16'h0003, 16'h0080, 2'd2, 4'd10, 16'h0002, 3'b010},
    '{16'hFFFF, 16'h0080, 2'd2, 4'd11, 16'h0000, 3'b110}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_census", 32'(census), 32'd0);
    check("rst_out_z", 32'(out_z), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic vectors, issued back-to-back with no back-pressure.
    for (int i = 0; i < NV; i++)
      send(VECS[i].a, VECS[i].b, VECS[i].r, VECS[i].id, VECS[i].z, VECS[i].st, 1'b1);
    drain();

    // Stream ids 0..9 with out_ready held low in relative cycles 3..9.
    cpeak = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'(i << 8), 16'h0100, 2'd0, IW'(i), 16'(i << 8),
               (i == 0) ? 3'b100 : 3'b000, 1'b0);
      end
      begin
        for (int r = 0; r < 14; r++) begin
          out_ready = !(r >= 3 && r <= 9);
          if (r == 9) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_census", 32'(census), 32'(CMAX));
          end
`ifndef MULT_PIPE_SKID_EN
          if (r == 10) begin
            #1;
            check("ready_ripple", 32'(in_ready), 32'd1);
          end
`endif
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("census_peak", 32'(cpeak), 32'(CMAX));

    // Reset with three entries in flight.
    out_ready = 1'b0;
    send(16'h0100, 16'h0100, 2'd0, 4'd1, 16'h0100, 3'b000, 1'b0);
    send(16'h0100, 16'h0200, 2'd0, 4'd2, 16'h0200, 3'b000, 1'b0);
    send(16'h0100, 16'h0300, 2'd0, 4'd3, 16'h0300, 3'b000, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_census", 32'(census), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_census", 32'(census), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(16'h0200, 16'h0200, 2'd0, 4'd5, 16'h0400, 3'b000, 1'b1);
    drain();

    // Wrapping instance: 0x7FFF * 0x7FFF keeps the low 16 bits of r.
    w_in_a     = 16'h7FFF;
    w_in_b     = 16'h7FFF;
    w_in_valid = 1'b1;
    @(negedge clk);
    check("wrap_in_ready", 32'(w_in_ready), 32'd1);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (w_out_valid) begin
          seen = 1'b1;
          check("wrap_z", 32'(w_out_z), 32'h0000FF00);
          check("wrap_status", 32'(w_status), 32'b011);
          check("wrap_id", 32'(w_out_id), 32'd1);
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout: got out_valid=0 expected 1");
      end
    end

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
